// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, types and constants for the pipelined register file
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xword_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve-over-writeback priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             wen,
    input  logic [AW-1:0]    rd,
    output logic [NREGS-1:0] busy_next
);

    logic [NREGS-1:0] busy;

    // Next-state: a new reservation beats a completing writeback; x0 is never busy
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_next[r] = busy[r];
            if (wen && rd == AW'(r)) begin
                busy_next[r] = 1'b0;
            end
            if (rsv_en && rsv_addr == AW'(r)) begin
                busy_next[r] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Busy state; reset discards every outstanding reservation
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with registered read ports, write-first bypass, stall and busy scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NUM_READ = 2,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [NUM_READ*AW-1:0]   rs_addr,
    output logic [NUM_READ*XLEN-1:0] rs_data,
    output logic [NUM_READ-1:0]      rs_busy,
    input  logic                     wen,
    input  logic [AW-1:0]            rd,
    input  logic [XLEN-1:0]          rd_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy_next;
    logic             wr_live;

    // A write to x0 is dropped everywhere, including the bypass path
    assign wr_live = wen && (rd != '0);

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .wen       (wen),
        .rd        (rd),
        .busy_next (busy_next)
    );

    // Data array; x0 is only ever written by reset so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_live) begin
            regs[rd] <= rd_data;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_d;
        logic [XLEN-1:0] data_q;
        logic            busy_q;

        assign addr = rs_addr[i*AW +: AW];

        // Write-first: an in-flight write to the addressed register is forwarded
        always_comb begin
            data_d = regs[addr];
            if (wr_live && rd == addr) begin
                data_d = rd_data;
            end
            if (addr == '0) begin
                data_d = '0;
            end
        end

        // Registered read port; rd_en low freezes both data and busy
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (rd_en) begin
                data_q <= data_d;
                busy_q <= busy_next[addr];
            end
        end

        assign rs_data[i*XLEN +: XLEN] = data_q;
        assign rs_busy[i]              = busy_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - table-driven self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NUM_READ = 2;
    localparam int AW       = 5;

    logic                     clk;
    logic                     rst;
    logic                     rd_en;
    logic [NUM_READ*AW-1:0]   rs_addr;
    logic [NUM_READ*XLEN-1:0] rs_data;
    logic [NUM_READ-1:0]      rs_busy;
    logic                     wen;
    logic [AW-1:0]            rd;
    logic [XLEN-1:0]          rd_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;

    regfile_sb #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NUM_READ (NUM_READ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rs_addr  (rs_addr),
        .rs_data  (rs_data),
        .rs_busy  (rs_busy),
        .wen      (wen),
        .rd       (rd),
        .rd_data  (rd_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        rd_en;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic        exp_b0;
        logic        exp_b1;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(string nm, logic r, logic re, logic [4:0] a0, logic [4:0] a1,
                                logic w, logic [4:0] wa, logic [31:0] wd, logic rs, logic [4:0] ra,
                                logic [31:0] d0, logic [31:0] d1, logic b0, logic b1);
        vec_t v;
        v.name = nm; v.rst = r; v.rd_en = re; v.a0 = a0; v.a1 = a1;
        v.wen = w; v.rd = wa; v.wdata = wd; v.rsv_en = rs; v.rsv_addr = ra;
        v.exp_d0 = d0; v.exp_d1 = d1; v.exp_b0 = b0; v.exp_b1 = b1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then compare both ports
    task automatic apply(input vec_t v);
        rst      = v.rst;
        rd_en    = v.rd_en;
        rs_addr  = {v.a1, v.a0};
        wen      = v.wen;
        rd       = v.rd;
        rd_data  = v.wdata;
        rsv_en   = v.rsv_en;
        rsv_addr = v.rsv_addr;
        @(posedge clk);
        #1;
        check({v.name, ".d0"}, rs_data[31:0], v.exp_d0);
        check({v.name, ".d1"}, rs_data[63:32], v.exp_d1);
        check({v.name, ".b0"}, {31'd0, rs_busy[0]}, {31'd0, v.exp_b0});
        check({v.name, ".b1"}, {31'd0, rs_busy[1]}, {31'd0, v.exp_b1});
    endtask

    vec_t vecs[17];

    initial begin
        //            name        rst re a0  a1  wen rd  wdata          rsv ra  exp_d0         exp_d1         b0 b1
        vecs[0]  = mk("rst0",     1, 0, 0,  0,  0,  0,  32'h0,         0,  0,  32'h0,         32'h0,         0, 0);
        vecs[1]  = mk("rst1",     1, 1, 5,  3,  1,  5,  32'hBAD,       1,  5,  32'h0,         32'h0,         0, 0);
        vecs[2]  = mk("rd_post",  0, 1, 5,  3,  0,  0,  32'h0,         0,  0,  32'h0,         32'h0,         0, 0);
        vecs[3]  = mk("wr7",      0, 1, 5,  3,  1,  7,  32'hDEADBEEF,  0,  0,  32'h0,         32'h0,         0, 0);
        vecs[4]  = mk("rd7",      0, 1, 7,  0,  0,  0,  32'h0,         0,  0,  32'hDEADBEEF,  32'h0,         0, 0);
        vecs[5]  = mk("byp9",     0, 1, 9,  9,  1,  9,  32'h12345678,  0,  0,  32'h12345678,  32'h12345678,  0, 0);
        vecs[6]  = mk("wr_x0",    0, 1, 0,  9,  1,  0,  32'hFFFFFFFF,  0,  0,  32'h0,         32'h12345678,  0, 0);
        vecs[7]  = mk("rd_x0",    0, 1, 0,  7,  0,  0,  32'h0,         0,  0,  32'h0,         32'hDEADBEEF,  0, 0);
        vecs[8]  = mk("rsv4",     0, 1, 4,  4,  0,  0,  32'h0,         1,  4,  32'h0,         32'h0,         1, 1);
        vecs[9]  = mk("busy4",    0, 1, 4,  7,  0,  0,  32'h0,         0,  0,  32'h0,         32'hDEADBEEF,  1, 0);
        vecs[10] = mk("wb4",      0, 1, 4,  0,  1,  4,  32'h44,        0,  0,  32'h44,        32'h0,         0, 0);
        vecs[11] = mk("free4",    0, 1, 4,  4,  0,  0,  32'h0,         0,  0,  32'h44,        32'h44,        0, 0);
        vecs[12] = mk("rsvwb4",   0, 1, 4,  4,  1,  4,  32'h55,        1,  4,  32'h55,        32'h55,        1, 1);
        vecs[13] = mk("still4",   0, 1, 4,  0,  0,  0,  32'h0,         0,  0,  32'h55,        32'h0,         1, 0);
        vecs[14] = mk("rsv_x0",   0, 1, 0,  0,  0,  0,  32'h0,         1,  0,  32'h0,         32'h0,         0, 0);
        vecs[15] = mk("x0_free",  0, 1, 0,  4,  0,  0,  32'h0,         0,  0,  32'h0,         32'h55,        0, 1);
        vecs[16] = mk("wr_free7", 0, 1, 7,  7,  1,  7,  32'h77,        0,  0,  32'h77,        32'h77,        0, 0);

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i]);
        end

        // Stall: outputs freeze while a write to 7 and a reserve of 9 still land
        apply(mk("stl_a",  0, 1, 7,  4,  1,  7,  32'hDEADBEEF,  0,  0,  32'hDEADBEEF,  32'h55,        0, 1));
        apply(mk("stl_b",  0, 0, 3,  9,  1,  7,  32'h1,         1,  9,  32'hDEADBEEF,  32'h55,        0, 1));
        apply(mk("stl_c",  0, 0, 0,  0,  0,  0,  32'h0,         0,  0,  32'hDEADBEEF,  32'h55,        0, 1));
        apply(mk("stl_d",  0, 1, 7,  9,  0,  0,  32'h0,         0,  0,  32'h1,         32'h12345678,  0, 1));

        // Reset mid-operation: reservations and stored data are discarded, same-cycle write lost
        apply(mk("mid_a",  0, 1, 10, 11, 1,  11, 32'hA5A5A5A5,  1,  10, 32'h0,         32'hA5A5A5A5,  1, 0));
        apply(mk("mid_b",  0, 1, 10, 11, 0,  0,  32'h0,         0,  0,  32'h0,         32'hA5A5A5A5,  1, 0));
        apply(mk("mid_rst",1, 1, 10, 11, 1,  12, 32'h12,        1,  13, 32'h0,         32'h0,         0, 0));
        apply(mk("mid_c",  0, 1, 10, 11, 0,  0,  32'h0,         0,  0,  32'h0,         32'h0,         0, 0));
        apply(mk("mid_d",  0, 1, 12, 9,  0,  0,  32'h0,         0,  0,  32'h0,         32'h0,         0, 0));
        apply(mk("mid_e",  0, 1, 13, 7,  0,  0,  32'h0,         0,  0,  32'h0,         32'h0,         0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
